uart_rx_param: RTL

//  Parametrised UART receiver: oversampled start detect, mid-bit sampling, N data bits LSB first,

---
 rtl/uart_rx_param.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: start detect, mid-bit sampling, LSB-first data, stop check, valid/ready output.
// Define UART_RX_PARITY_EN to receive and check a parity bit between the last data bit and the stop bit.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  localparam logic PAR_SENSE = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BRK    = 3'd5;

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 par_bad_q, par_bad_d;
  logic                 cmpl_q, cmpl_d;
  logic                 frame_err_q, frame_err_d;
  logic                 par_err_q, par_err_d;
  logic                 ovr_q, ovr_d;
  logic                 vld_q, vld_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 shift_we;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    par_bad_d   = par_bad_q;
    cmpl_d      = 1'b0;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;
    ovr_d       = 1'b0;
    vld_d       = vld_q;
    data_d      = data_q;
    shift_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            idx_d     = '0;
            par_bad_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          shift_we = 1'b1;
          if (idx_q == IDX_LAST) state_d = PAR_EN ? S_PARITY : S_STOP;
          else                   idx_d   = idx_q + IW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = (rx_s_q != ((^shift_q) ^ PAR_SENSE));
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            cmpl_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Broken stop: drop the word, report both errors, and wait out the low line
            frame_err_d = 1'b1;
            par_err_d   = par_bad_q;
            state_d     = S_BRK;
          end
        end
      end
      S_BRK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Output register: a completed word wins over a plain accept in the same cycle
    if (cmpl_q) begin
      par_err_d = par_bad_q;
      if (!vld_q || out_ready) begin
        data_d = shift_q;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      par_bad_q   <= 1'b0;
      cmpl_q      <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      ovr_q       <= 1'b0;
      vld_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      par_bad_q   <= par_bad_d;
      cmpl_q      <= cmpl_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
      ovr_q       <= ovr_d;
      vld_q       <= vld_d;
      data_q      <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_we) shift_q[idx_q] <= rx_s_q;
  end

  assign out_data   = data_q;
  assign out_valid  = vld_q;
  assign frame_err  = frame_err_q;
  assign parity_err = PAR_EN & par_err_q;
  assign overrun    = ovr_q;
endmodule
